mdu_div: RTL and testbench

- Iterative RV32M divide unit. Executes DIV, DIVU, REM and REMU, which the single-cycle ALU does not handle.
- Sits beside the ALU in the execute stage. The pipeline sends one request and stalls until the response is consumed.
- Radix-2 restoring division, one quotient bit per cycle. Divide-by-zero and signed overflow take a fast path.

---
 rtl/mdu_div.sv | 141 ++++++++++++++
 tb/tb_mdu_div.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring radix-2, one quotient bit per cycle, XLEN+1 cycles to response.
// Zero divisor / signed overflow answer after one cycle; DONE holds the result until resp_ready_i or kill_i.
module mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            kill_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            rem_sel_q, rem_sel_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            signed_op, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, rem_nx, quo_nx, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, trial;

  always_comb begin
    state_d      = state_q;
    rem_sel_d    = rem_sel_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;

    signed_op = ~op_i[0];
    a_neg     = signed_op & dividend_i[XLEN-1];
    b_neg     = signed_op & divisor_i[XLEN-1];
    abs_a     = a_neg ? -dividend_i : dividend_i;
    abs_b     = b_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);

    // Trial subtract is one bit wider so its MSB is the borrow.
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (trial[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
    q_fix = q_neg_q ? -quo_nx : quo_nx;
    r_fix = r_neg_q ? -rem_nx : rem_nx;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !kill_i) begin
          rem_sel_d = op_i[1];
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          if (div_zero) begin
            res_d   = op_i[1] ? dividend_i : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = DONE;
          end else begin
            cnt_d   = CW'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == '0) begin
            res_d   = rem_sel_q ? r_fix : q_fix;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        if (kill_i || resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: tb/tb_mdu_div.sv
// Scoreboarded bench for mdu_div: results and latencies queued at issue, compared at response.
module tb_mdu_div;

  logic        clk_i = 1'b0;
  logic        reset_i, kill_i, req_valid_i, resp_ready_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic        req_ready_o, resp_valid_o;
  logic [31:0] result_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  mdu_div #(.XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int NT = 14;
  logic [1:0]  t_op  [NT] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
  logic [31:0] t_a   [NT] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd5, 32'hDEADBEEF, 32'd5, 32'hDEADBEEF,
                              32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
  logic [31:0] t_b   [NT] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h10, 32'h10,
                              32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_exp [NT] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'h0FFFFFFF, 32'hF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'hDEADBEEF,
                              32'h80000000, 32'd0, 32'd0, 32'h80000000};

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : 32'h80000000;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  // Accept happens at the posedge inside; returns #1 after it with operands scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input int el, input bit push);
    @(negedge clk_i);
    op_i = op; dividend_i = a; divisor_i = b; req_valid_i = 1'b1;
    if (push) begin
      exp_res_q.push_back(er);
      exp_lat_q.push_back(el);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; op_i = ~op; dividend_i = $urandom; divisor_i = $urandom;
  endtask

  // lat = 1 means valid seen right after the accept edge.
  task automatic collect(output logic [31:0] res, output int lat, output bit ready_low);
    lat = 1; ready_low = 1'b1;
    while (!resp_valid_o && lat < 100) begin
      if (req_ready_o) ready_low = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end
    if (req_ready_o) ready_low = 1'b0;
    res = result_o;
  endtask

  task automatic consume();
    @(negedge clk_i); resp_ready_i = 1'b1;
    @(posedge clk_i); #1; resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; kill_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    op_i = 2'd0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h, want 1 0 00000000", req_ready_o, resp_valid_o, result_o);
    end
    @(negedge clk_i); reset_i = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] a, b, er, got, exp;
    logic [1:0]  op;
    int          lat, elat;
    bit          rdy_low;
    for (int i = 0; i < NT + 6; i++) begin
      if (i < NT) begin
        op = t_op[i]; a = t_a[i]; b = t_b[i]; er = t_exp[i];
      end else begin
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 30);
        er = model(op, a, b);
      end
      issue(op, a, b, er, model_lat(op, a, b), 1'b1);
      collect(got, lat, rdy_low);
      vectors++;
      if (exp_res_q.size() == 0) begin
        miscompares++;
        $display("FAIL arith_queue row %0d: scoreboard empty", i);
      end else begin
        exp = exp_res_q.pop_front(); elat = exp_lat_q.pop_front();
        vectors += 2;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL arith_result row %0d op=%0d %h/%h: got %h want %h", i, op, a, b, got, exp);
        end
        if (lat !== elat) begin
          miscompares++;
          $display("FAIL arith_latency row %0d: got %0d want %0d", i, lat, elat);
        end
      end
      vectors++;
      if (!rdy_low) begin
        miscompares++;
        $display("FAIL busy_ready row %0d: req_ready_o=1 while busy, want 0", i);
      end
      consume();
      vectors++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL release row %0d: valid=%b ready=%b want 0 1", i, resp_valid_o, req_ready_o);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, held;
    int lat;
    bit rdy_low;
    issue(2'd1, 32'd1000, 32'd3, 32'd333, 33, 1'b1);
    collect(got, lat, rdy_low);
    vectors++;
    if (got !== exp_res_q.pop_front() || lat !== exp_lat_q.pop_front()) begin
      miscompares++;
      $display("FAIL bp_result: got %h lat %0d want 0000014d lat 33", got, lat);
    end
    held = result_o;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      vectors++;
      if (resp_valid_o !== 1'b1 || result_o !== held) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: valid=%b result=%h want 1 %h", c, resp_valid_o, result_o, held);
      end
    end
    @(negedge clk_i); kill_i = 1'b1; resp_ready_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0; resp_ready_i = 1'b0;
    vectors++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_done: valid=%b ready=%b want 0 1", resp_valid_o, req_ready_o);
    end
    issue(2'd1, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    collect(got, lat, rdy_low);
    vectors++;
    if (got !== exp_res_q.pop_front() || lat !== exp_lat_q.pop_front()) begin
      miscompares++;
      $display("FAIL after_kill: got %h lat %0d want 0000000e lat 33", got, lat);
    end
    consume();
  endtask

  task automatic test_abort();
    logic [31:0] got;
    int lat;
    bit rdy_low, seen;
    // kill in IDLE must block acceptance
    @(negedge clk_i);
    op_i = 2'd1; dividend_i = 32'd50; divisor_i = 32'd5; req_valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1; req_valid_i = 1'b0; kill_i = 1'b0;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_idle: ready=%b valid=%b want 1 0", req_ready_o, resp_valid_o);
    end
    issue(2'd1, 32'd999, 32'd4, 32'd0, 0, 1'b0);
    repeat (14) @(posedge clk_i);
    @(negedge clk_i); kill_i = 1'b1;
    @(posedge clk_i); #1; kill_i = 1'b0;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_calc: ready=%b valid=%b want 1 0", req_ready_o, resp_valid_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (resp_valid_o) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL kill_noresp: resp_valid_o=1 after kill, want 0");
    end
    issue(2'd0, 32'd12345, 32'd17, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i); #1; reset_i = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: ready=%b valid=%b result=%h want 1 0 00000000", req_ready_o, resp_valid_o, result_o);
    end
    #1; reset_i = 1'b0;
    issue(2'd3, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    collect(got, lat, rdy_low);
    vectors++;
    if (got !== exp_res_q.pop_front() || lat !== exp_lat_q.pop_front()) begin
      miscompares++;
      $display("FAIL after_reset: got %h lat %0d want 00000002 lat 33", got, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_abort();
    vectors++;
    if (exp_res_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
